// File: rtl/thunderbird_pkg.sv
// Shared lamp-pattern constants, state codes and pattern classifier for the thunderbird tail-light family.
package thunderbird_pkg;

  localparam logic [5:0] PAT_IDLE = 6'b000000;
  localparam logic [5:0] PAT_L1   = 6'b001000;
  localparam logic [5:0] PAT_L2   = 6'b011000;
  localparam logic [5:0] PAT_L3   = 6'b111000;
  localparam logic [5:0] PAT_R1   = 6'b000100;
  localparam logic [5:0] PAT_R2   = 6'b000110;
  localparam logic [5:0] PAT_R3   = 6'b000111;
  localparam logic [5:0] PAT_LR   = 6'b111111;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_L1   = 3'd1;
  localparam logic [2:0] ST_L2   = 3'd2;
  localparam logic [2:0] ST_L3   = 3'd3;
  localparam logic [2:0] ST_R1   = 3'd4;
  localparam logic [2:0] ST_R2   = 3'd5;
  localparam logic [2:0] ST_R3   = 3'd6;
  localparam logic [2:0] ST_LR   = 3'd7;

  typedef struct packed {
    logic       valid;
    logic [2:0] code;
  } pat_class_t;

  function automatic pat_class_t classify_pattern(input logic [5:0] pat);
    pat_class_t c;
    c.valid = 1'b1;
    c.code  = ST_IDLE;
    case (pat)
      PAT_IDLE: c.code = ST_IDLE;
      PAT_L1:   c.code = ST_L1;
      PAT_L2:   c.code = ST_L2;
      PAT_L3:   c.code = ST_L3;
      PAT_R1:   c.code = ST_R1;
      PAT_R2:   c.code = ST_R2;
      PAT_R3:   c.code = ST_R3;
      PAT_LR:   c.code = ST_LR;
      default:  c.valid = 1'b0;
    endcase
    return c;
  endfunction

  // Step states are the six turn-signal phases; IDLE and LR are steady states.
  function automatic logic is_step(input logic [2:0] code);
    return (code != ST_IDLE) && (code != ST_LR);
  endfunction

endpackage

// File: rtl/thunderbird_pattern_class.sv
// Combinational classifier: 6-bit lamp vector -> {valid, state code}.
module thunderbird_pattern_class
  import thunderbird_pkg::*;
(
  input  logic [5:0] i_light,
  output logic       o_valid,
  output logic [2:0] o_code
);

  pat_class_t w_class;

  always_comb begin
    w_class = classify_pattern(i_light);
  end

  assign o_valid = w_class.valid;
  assign o_code  = w_class.code;

endmodule

// File: rtl/thunderbird_decoder.sv
// Receive-side monitor for the thunderbird lamp vector: decodes state, checks legality, counts errors.
// Optional step dwell-time checking is enabled by defining THUNDERBIRD_DEC_DWELL_CHECK_EN.
module thunderbird_decoder
  import thunderbird_pkg::*;
#(
  parameter int MIN_DWELL = 3,
  parameter int MAX_DWELL = 3,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       light_in,
  output logic             left_on,
  output logic             right_on,
  output logic             hazard_on,
  output logic             seq_done,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       dec_state
);

  if (MIN_DWELL > MAX_DWELL + 1) begin : g_param_chk
    $error("MIN_DWELL can never be met before the stuck limit");
  end

  logic       w_valid;
  logic [2:0] w_code;

  thunderbird_pattern_class u_class (
    .i_light (light_in),
    .o_valid (w_valid),
    .o_code  (w_code)
  );

  logic [2:0]       r_state;
  logic             r_unk;
  logic [5:0]       r_prev_light;
  logic             r_seq_done;
  logic             r_err;
  logic [ERR_W-1:0] r_err_count;

  logic [2:0] w_state_nxt;
  logic       w_unk_nxt;
  logic       w_legal;
  logic       w_err_seq;
  logic       w_err;
  logic       w_done;
  logic       w_dwell_err;

`ifdef THUNDERBIRD_DEC_DWELL_CHECK_EN
  localparam int DW_MAX = (MIN_DWELL > MAX_DWELL) ? MIN_DWELL : MAX_DWELL;
  localparam int DW_W   = $clog2(DW_MAX + 2);
  localparam logic [DW_W-1:0] MIN_D = DW_W'(MIN_DWELL);
  localparam logic [DW_W-1:0] MAX_D = DW_W'(MAX_DWELL);
  localparam logic [DW_W-1:0] ONE_D = DW_W'(1);

  logic [DW_W-1:0] r_dwell;
  logic [DW_W-1:0] w_dwell_nxt;

  // Dwell counts cycles the current state has been observed, including its entry cycle.
  always_comb begin
    w_dwell_nxt = r_dwell;
    w_dwell_err = 1'b0;
    if (r_unk) begin
      w_dwell_nxt = w_valid ? ONE_D : '0;
    end else if (!w_valid) begin
      w_dwell_nxt = '0;
      w_dwell_err = is_step(r_state) && (r_dwell < MIN_D);
    end else if (w_code == r_state) begin
      if (r_dwell <= MAX_D) w_dwell_nxt = r_dwell + ONE_D;
      w_dwell_err = is_step(r_state) && (r_dwell == MAX_D);
    end else begin
      w_dwell_nxt = ONE_D;
      w_dwell_err = is_step(r_state) && (r_dwell < MIN_D);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_dwell <= '0;
    else       r_dwell <= w_dwell_nxt;
  end
`else
  assign w_dwell_err = 1'b0;
`endif

  always_comb begin
    w_legal = (w_code == ST_IDLE) || (w_code == ST_LR);
    case (r_state)
      ST_IDLE: if ((w_code == ST_L1) || (w_code == ST_R1)) w_legal = 1'b1;
      ST_L1:   if (w_code == ST_L2) w_legal = 1'b1;
      ST_L2:   if (w_code == ST_L3) w_legal = 1'b1;
      ST_R1:   if (w_code == ST_R2) w_legal = 1'b1;
      ST_R2:   if (w_code == ST_R3) w_legal = 1'b1;
      default: ;
    endcase
  end

  // While UNK the state register is parked at IDLE so dec_state reads 0.
  always_comb begin
    w_state_nxt = r_state;
    w_unk_nxt   = r_unk;
    w_err_seq   = 1'b0;
    w_done      = 1'b0;
    if (r_unk) begin
      if (!w_valid) begin
        w_err_seq = (light_in != r_prev_light);
      end else begin
        w_unk_nxt   = 1'b0;
        w_state_nxt = w_code;
        w_err_seq   = is_step(w_code);
      end
    end else if (!w_valid) begin
      w_unk_nxt   = 1'b1;
      w_state_nxt = ST_IDLE;
      w_err_seq   = 1'b1;
    end else if (w_code != r_state) begin
      w_state_nxt = w_code;
      w_err_seq   = !w_legal;
      w_done      = w_legal && (w_code == ST_IDLE) &&
                    ((r_state == ST_L3) || (r_state == ST_R3));
    end
    w_err = w_err_seq || w_dwell_err;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_unk       <= 1'b0;
      r_seq_done  <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_unk      <= w_unk_nxt;
      r_seq_done <= w_done;
      r_err      <= w_err;
      if (w_err && (r_err_count != {ERR_W{1'b1}})) r_err_count <= r_err_count + 1'b1;
    end
  end

  // Previous raw vector: distinguishes a held BAD value from a new one.
  always_ff @(posedge clk) begin
    r_prev_light <= light_in;
  end

  assign left_on   = (r_state == ST_L1) || (r_state == ST_L2) || (r_state == ST_L3);
  assign right_on  = (r_state == ST_R1) || (r_state == ST_R2) || (r_state == ST_R3);
  assign hazard_on = (r_state == ST_LR);
  assign seq_done  = r_seq_done;
  assign err       = r_err;
  assign err_count = r_err_count;
  assign dec_state = r_state;

endmodule
